// File: rtl/rr_arbiter_pkg.sv
// Shared arbitration constants and the elaboration-time range check for PORTS.
// The range-check macro sits beside the package so every arbiter variant gets the same guard.
`ifndef RR_ARBITER_PKG_SV
`define RR_ARBITER_PKG_SV

`define RR_ARB_CHECK_PORTS(P) \
    if ((P) < 2 || (P) > 32) begin : g_ports_range_err \
        $error("rr_arbiter: PORTS must be in 2..32"); \
    end

package rr_arbiter_pkg;
    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;
endpackage

`endif

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder: valid_o when any bit is set, idx_o is the lowest set bit.
module priority_encoder #(
    parameter int WIDTH = 4,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with registered one-hot grant, encoded select and
// optional grant holding (while requested, or until the holder acknowledges).
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS       = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int BLOCK       = 1,
    parameter int BLOCK_ACK   = 0,
    localparam int IW = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IW-1:0]    grant_encoded
);

    `RR_ARB_CHECK_PORTS(PORTS)

    localparam bit MODE = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;

    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic [IW-1:0]    grant_enc_q, grant_enc_d;
    logic             grant_valid_q, grant_valid_d;

    logic [PORTS-1:0] masked_req;
    logic             masked_valid, any_req;
    logic [IW-1:0]    masked_idx, unmasked_idx, winner;
    logic             rel_hold, free;

    assign masked_req = request & mask_q;

    priority_encoder #(.WIDTH(PORTS)) u_pe_masked (
        .req_i   (masked_req),
        .valid_o (masked_valid),
        .idx_o   (masked_idx)
    );

    priority_encoder #(.WIDTH(PORTS)) u_pe_unmasked (
        .req_i   (request),
        .valid_o (any_req),
        .idx_o   (unmasked_idx)
    );

    // Acknowledge mode ignores the holder's request level; blocking mode releases on request drop.
    always_comb begin
        if (BLOCK_ACK != 0) begin
            rel_hold = grant_valid_q & acknowledge[grant_enc_q];
        end else if (BLOCK != 0) begin
            rel_hold = ~request[grant_enc_q];
        end else begin
            rel_hold = 1'b1;
        end
    end

    assign free   = ~grant_valid_q | rel_hold;
    assign winner = masked_valid ? masked_idx : unmasked_idx;

    always_comb begin
        grant_d       = grant_q;
        grant_enc_d   = grant_enc_q;
        grant_valid_d = grant_valid_q;
        mask_d        = mask_q;
        if (free) begin
            if (any_req) begin
                grant_d       = {{(PORTS-1){1'b0}}, 1'b1} << winner;
                grant_enc_d   = winner;
                grant_valid_d = 1'b1;
                // Only ports above the winner stay preferred; winner PORTS-1 empties the mask.
                if (MODE == ARB_RR) begin
                    mask_d = ({PORTS{1'b1}} << winner) << 1;
                end else begin
                    mask_d = '1;
                end
            end else begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            grant_enc_q   <= '0;
            grant_valid_q <= 1'b0;
            mask_q        <= '1;
        end else begin
            grant_q       <= grant_d;
            grant_enc_q   <= grant_enc_d;
            grant_valid_q <= grant_valid_d;
            mask_q        <= mask_d;
        end
    end

    assign grant         = grant_q;
    assign grant_encoded = grant_enc_q;
    assign grant_valid   = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: four configurations side by side, each checked every cycle against a
// pointer-based behavioural model, plus directed scenarios with hand-computed expectations.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req  [4];
    logic [3:0] ack  [4];
    logic [3:0] gnt  [4];
    logic       gv   [4];
    logic [1:0] genc [4];
    bit         cmp_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: RR + blocking, 1: RR re-arbitrate, 2: acknowledge hold, 3: fixed priority
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(1), .BLOCK_ACK(0)) u_blk (
        .clk(clk), .rst_n(rst_n), .request(req[0]), .acknowledge(ack[0]),
        .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(genc[0]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(0), .BLOCK_ACK(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .request(req[1]), .acknowledge(ack[1]),
        .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(genc[1]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(1), .BLOCK_ACK(1)) u_ack (
        .clk(clk), .rst_n(rst_n), .request(req[2]), .acknowledge(ack[2]),
        .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(genc[2]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK(0), .BLOCK_ACK(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .request(req[3]), .acknowledge(ack[3]),
        .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(genc[3]));

    // Behavioural model: holder index plus "last winner" pointer for rotation.
    localparam bit RR_C  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit BLK_C [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam bit ACK_C [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int m_valid [4];
    int m_idx   [4];
    int m_last  [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 0;
            m_idx[k]   = 0;
            m_last[k]  = -1;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r, input logic [3:0] a);
        bit is_free;
        int w;
        if (m_valid[k] == 0)  is_free = 1'b1;
        else if (ACK_C[k])    is_free = a[m_idx[k]];
        else if (BLK_C[k])    is_free = !r[m_idx[k]];
        else                  is_free = 1'b1;
        if (!is_free) return;
        if (r == 4'b0000) begin
            m_valid[k] = 0;
            return;
        end
        w = -1;
        if (RR_C[k]) begin
            for (int i = m_last[k] + 1; i < 4; i++) if (r[i] && w < 0) w = i;
        end
        for (int i = 0; i < 4; i++) if (r[i] && w < 0) w = i;
        m_valid[k] = 1;
        m_idx[k]   = w;
        if (RR_C[k]) m_last[k] = w;
    endtask

    function automatic int exp_grant(input int k);
        return (m_valid[k] != 0) ? (1 << m_idx[k]) : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int k = 0; k < 4; k++) model_step(k, req[k], ack[k]);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("cyc_grant_%0d", k), int'(gnt[k]), exp_grant(k));
                check($sformatf("cyc_valid_%0d", k), int'(gv[k]), m_valid[k]);
                check($sformatf("cyc_enc_%0d", k), int'(genc[k]), m_idx[k]);
            end
        end
    end

    // Directed check: DUT and model both pinned to hand-computed values.
    task automatic dchk(input string name, input int k, input int eg, input int ev, input int ee);
        check({name, "_grant"}, int'(gnt[k]), eg);
        check({name, "_valid"}, int'(gv[k]), ev);
        check({name, "_enc"}, int'(genc[k]), ee);
        check({name, "_mgrant"}, exp_grant(k), eg);
        check({name, "_mvalid"}, m_valid[k], ev);
        check({name, "_menc"}, m_idx[k], ee);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[k] = 4'b0000;
            ack[k] = 4'b0000;
        end
        cmp_en = 1'b1;
        repeat (3) tick();
        dchk("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a held grant
        req[0] = 4'b0010;
        tick();
        dchk("t1_grant", 0, 4'b0010, 1, 1);
        rst_n = 1'b0;
        #1;
        dchk("t1_async_rst", 0, 0, 0, 0);
        req[0] = 4'b0001;
        tick();
        rst_n = 1'b1;
        tick();
        dchk("t1_after_rst", 0, 4'b0001, 1, 0);

        // Blocking hold, then hand-over without an idle cycle
        req[0] = 4'b0101;
        repeat (5) begin
            tick();
            dchk("t3_hold", 0, 4'b0001, 1, 0);
        end
        req[0] = 4'b0100;
        tick();
        dchk("t3_switch", 0, 4'b0100, 1, 2);
        req[0] = 4'b0000;
        tick();

        // Rotation with all ports requesting, then wrap from index 3
        req[1] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            dchk("t2_rot", 1, 1 << (i % 4), 1, i % 4);
        end
        req[1] = 4'b1001;
        tick();
        dchk("t5_wrap", 1, 4'b0001, 1, 0);
        tick();
        dchk("t5_next", 1, 4'b1000, 1, 3);
        req[1] = 4'b0000;
        tick();

        // Acknowledge-held grant
        req[2] = 4'b0010;
        tick();
        dchk("t4_grant", 2, 4'b0010, 1, 1);
        req[2] = 4'b0000;
        tick();
        dchk("t4_noack", 2, 4'b0010, 1, 1);
        ack[2] = 4'b1000;
        tick();
        dchk("t4_otherack", 2, 4'b0010, 1, 1);
        ack[2] = 4'b0010;
        tick();
        dchk("t4_release", 2, 0, 0, 1);
        ack[2] = 4'b0000;

        // Fixed priority
        req[3] = 4'b1110;
        repeat (3) begin
            tick();
            dchk("t6_fixed", 3, 4'b0010, 1, 1);
        end
        req[3] = 4'b1000;
        tick();
        dchk("t6_top", 3, 4'b1000, 1, 3);
        req[3] = 4'b0000;
        tick();

        // Randomized traffic with sticky requests, sparse acks and occasional async reset
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) req[k] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) ack[k] = 4'(1 << $urandom_range(0, 3));
                else ack[k] = 4'b0000;
            end
            if (c % 250 == 125) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
